// File: rtl/adc_spi_responder.sv
// adc_spi_responder
// Emulates the board's 4-channel, 12-bit serial ADC on the SPI bus so that
// sensor-driven logic can run against controlled sample values. The SPI pins
// are oversampled on the internal clock. Each frame receives a start bit, a
// mode bit and a 3-bit address. It then returns a null bit followed by the
// selected sample, MSB first.
//
// Ports:
//   clk         system clock; all SPI pins are oversampled on it
//   rst_n       asynchronous active-low reset
//   sclk        SPI serial clock from the initiator (asynchronous)
//   cs_n        chip select, active low (asynchronous)
//   din         serial command data, changes on sclk falling edges
//   ch0..ch3    sample values presented for channels 0..3
//   dout        serial sample data, updated after a synchronized sclk rise
//   dout_oe     high while a frame is active (synchronized cs_n low)
//   frame_done  one-clk pulse after a well-formed frame ends
//   last_addr   address decoded in the most recent frame
//   err         one-clk pulse on a malformed frame
module adc_spi_responder #(
   parameter int SYNC_STAGES = 2,
   parameter int DATA_W      = 12,
   parameter int NUM_CH      = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              sclk,
   input  logic              cs_n,
   input  logic              din,
   input  logic [DATA_W-1:0] ch0,
   input  logic [DATA_W-1:0] ch1,
   input  logic [DATA_W-1:0] ch2,
   input  logic [DATA_W-1:0] ch3,
   output logic              dout,
   output logic              dout_oe,
   output logic              frame_done,
   output logic [2:0]        last_addr,
   output logic              err
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] CMD   = 2'd1;
   localparam logic [1:0] XFER  = 2'd2;
   localparam logic [1:0] DRAIN = 2'd3;

   localparam logic [4:0] R_NULL = 5'd5;
   localparam logic [4:0] R_LAST = 5'(5 + DATA_W);
   localparam logic [3:0] NUM_CH_L = 4'(NUM_CH);

   logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, din_sync;
   logic                   sclk_prev, cs_prev;
   logic                   sclk_s, cs_s, din_s;
   logic                   sclk_rise, cs_fall, cs_rise;

   logic [1:0]        state;
   logic [4:0]        r_cnt, r_sat;
   logic [DATA_W-1:0] shift_reg;
   logic [2:0]        addr;
   logic              mode;
   logic              load_pend;
   logic              frame_bad;
   logic              xfer_done;

   logic [DATA_W-1:0] ch_sel, ch_pair, load_val;
   logic [DATA_W:0]   diff;

   // Synchronizers and edge-history flops. The cs_n chain resets to 0
   // (looks "selected"). If the initiator holds cs_n low through reset, no
   // false falling edge appears. The next real frame starts only after
   // cs_n has been seen high and then low again.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sclk_sync <= '0;
         cs_sync   <= '0;
         din_sync  <= '0;
         sclk_prev <= 1'b0;
         cs_prev   <= 1'b0;
      end else begin
         sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
         cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n};
         din_sync  <= {din_sync[SYNC_STAGES-2:0], din};
         sclk_prev <= sclk_s;
         cs_prev   <= cs_s;
      end
   end

   assign sclk_s    = sclk_sync[SYNC_STAGES-1];
   assign cs_s      = cs_sync[SYNC_STAGES-1];
   assign din_s     = din_sync[SYNC_STAGES-1];
   assign sclk_rise = sclk_s & ~sclk_prev;
   assign cs_fall   = ~cs_s & cs_prev;
   assign cs_rise   = cs_s & ~cs_prev;
   assign r_sat     = (r_cnt == 5'd31) ? 5'd31 : r_cnt + 5'd1;
   assign dout_oe   = ~cs_s & (state != IDLE);

   // Sample selection. The pseudo-differential result is computed one bit
   // wider so a negative difference shows up in the top bit and clamps to 0.
   always_comb begin
      ch_sel  = '0;
      ch_pair = '0;
      case (addr[1:0])
         2'd0: begin ch_sel = ch0; ch_pair = ch1; end
         2'd1: begin ch_sel = ch1; ch_pair = ch0; end
         2'd2: begin ch_sel = ch2; ch_pair = ch3; end
         default: begin ch_sel = ch3; ch_pair = ch2; end
      endcase
      diff = {1'b0, ch_sel} - {1'b0, ch_pair};
      if ({1'b0, addr} >= NUM_CH_L)
         load_val = '0;
      else if (mode)
         load_val = ch_sel;
      else if (diff[DATA_W])
         load_val = '0;
      else
         load_val = diff[DATA_W-1:0];
   end

   // Frame FSM. A cs_n rise always ends the frame, whatever the state. It
   // pulses frame_done for a completed error-free frame, or err for an
   // aborted frame that has not already flagged an error. The shift register
   // loads one clk after the last address bit, well before the next sclk
   // rise, so channel inputs are sampled only at that point.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         r_cnt      <= '0;
         shift_reg  <= '0;
         addr       <= '0;
         mode       <= 1'b0;
         load_pend  <= 1'b0;
         frame_bad  <= 1'b0;
         xfer_done  <= 1'b0;
         dout       <= 1'b0;
         frame_done <= 1'b0;
         err        <= 1'b0;
         last_addr  <= '0;
      end else begin
         frame_done <= 1'b0;
         err        <= 1'b0;
         if (cs_rise) begin
            state     <= IDLE;
            dout      <= 1'b0;
            load_pend <= 1'b0;
            if (state != IDLE) begin
               if (xfer_done) begin
                  if (!frame_bad)
                     frame_done <= 1'b1;
               end else if (!frame_bad) begin
                  err <= 1'b1;
               end
            end
         end else begin
            if (sclk_rise && state != IDLE)
               r_cnt <= r_sat;
            case (state)
               IDLE: begin
                  dout <= 1'b0;
                  if (cs_fall) begin
                     state     <= CMD;
                     r_cnt     <= '0;
                     addr      <= '0;
                     mode      <= 1'b0;
                     load_pend <= 1'b0;
                     frame_bad <= 1'b0;
                     xfer_done <= 1'b0;
                  end
               end
               CMD: begin
                  if (load_pend) begin
                     load_pend <= 1'b0;
                     shift_reg <= load_val;
                     last_addr <= addr;
                     state     <= XFER;
                     if ({1'b0, addr} >= NUM_CH_L) begin
                        err       <= 1'b1;
                        frame_bad <= 1'b1;
                     end
                  end else if (sclk_rise) begin
                     case (r_cnt)
                        5'd0: begin
                           if (!din_s) begin
                              err       <= 1'b1;
                              frame_bad <= 1'b1;
                              state     <= DRAIN;
                           end
                        end
                        5'd1: mode <= din_s;
                        5'd2, 5'd3: addr <= {addr[1:0], din_s};
                        5'd4: begin
                           addr      <= {addr[1:0], din_s};
                           load_pend <= 1'b1;
                        end
                        default: ;
                     endcase
                  end
               end
               XFER: begin
                  if (sclk_rise) begin
                     if (r_cnt == R_NULL) begin
                        dout <= 1'b0;
                     end else begin
                        dout      <= shift_reg[DATA_W-1];
                        shift_reg <= {shift_reg[DATA_W-2:0], 1'b0};
                        if (r_cnt == R_LAST) begin
                           state     <= DRAIN;
                           xfer_done <= 1'b1;
                        end
                     end
                  end
               end
               default: begin
                  if (sclk_rise)
                     dout <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_adc_spi_responder.sv
// tb_adc_spi_responder
// Self-checking bench for adc_spi_responder. An initiator task drives SPI
// frames with an sclk phase of PH clk periods and samples dout on each sclk
// falling edge. A reference model computes each expected sample directly
// from the channel values with integer arithmetic.
module tb_adc_spi_responder;

   localparam int PH = 8;

   logic        clk;
   logic        rst_n;
   logic        sclk;
   logic        cs_n;
   logic        din;
   logic [11:0] ch0, ch1, ch2, ch3;
   logic        dout;
   logic        dout_oe;
   logic        frame_done;
   logic [2:0]  last_addr;
   logic        err;

   int test_count = 0;
   int fail_count = 0;
   int done_count = 0;
   int err_count  = 0;
   int both_count = 0;
   int exp_last   = 0;

   adc_spi_responder #(.SYNC_STAGES(2), .DATA_W(12), .NUM_CH(4)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .sclk       (sclk),
      .cs_n       (cs_n),
      .din        (din),
      .ch0        (ch0),
      .ch1        (ch1),
      .ch2        (ch2),
      .ch3        (ch3),
      .dout       (dout),
      .dout_oe    (dout_oe),
      .frame_done (frame_done),
      .last_addr  (last_addr),
      .err        (err)
   );

   // 100 MHz system clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Pulse monitor, sampled on the falling clk edge away from updates
   always @(negedge clk) begin
      if (frame_done) done_count++;
      if (err) err_count++;
      if (frame_done && err) both_count++;
   end

   // Safety net so the run always ends
   initial begin
      #3ms;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      test_count++;
      if (obs !== exp) begin
         fail_count++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic int chanVal(input int idx);
      case (idx)
         0: return int'(ch0);
         1: return int'(ch1);
         2: return int'(ch2);
         default: return int'(ch3);
      endcase
   endfunction

   // Reference: a single-ended read returns the channel value. A
   // pseudo-differential read returns this channel minus its pair, floored
   // at 0. An out-of-range address returns 0.
   function automatic int modelSample(input bit mode, input int addr);
      int a, b;
      if (addr >= 4) return 0;
      a = chanVal(addr);
      b = chanVal(addr ^ 1);
      if (mode) return a;
      return (a - b < 0) ? 0 : a - b;
   endfunction

   // Runs one frame of n_rises sclk rises, then checks data and pulses.
   // chg_rise changes ch1 during that rise; rst_rise pulses rst_n there.
   task automatic applyStimulus(input bit start, input bit mode, input int addr,
                                input int n_rises, input int chg_rise,
                                input logic [11:0] chg_val, input int rst_rise);
      logic [4:0]  cmd;
      logic [17:0] rx;
      int          exp_val, got_val, err_base, done_base, err_early;
      bit          did_rst;
      cmd       = {start, mode, 3'(addr)};
      exp_val   = modelSample(mode, addr);
      err_base  = err_count;
      done_base = done_count;
      err_early = 0;
      rx        = '0;
      did_rst   = 1'b0;
      cs_n      = 1'b0;
      for (int r = 0; r < n_rises; r++) begin
         din = (r < 5) ? cmd[4-r] : 1'($urandom_range(0, 1));
         repeat (PH) @(negedge clk);
         sclk = 1'b1;
         if (r == chg_rise) ch1 = chg_val;
         repeat (PH) @(negedge clk);
         rx[r] = dout;
         if (r == 0) err_early = err_count - err_base;
         if (r == 2) checkOutput("dout_oe_active", 32'(dout_oe), 32'd1);
         if (r == rst_rise) begin
            rst_n = 1'b0;
            #1;
            checkOutput("reset_dout", 32'(dout), 32'd0);
            checkOutput("reset_oe", 32'(dout_oe), 32'd0);
            @(negedge clk);
            rst_n   = 1'b1;
            did_rst = 1'b1;
            sclk    = 1'b0;
            break;
         end
         sclk = 1'b0;
      end
      repeat (PH) @(negedge clk);
      cs_n = 1'b1;
      repeat (2 * PH) @(negedge clk);
      checkOutput("idle_oe", 32'(dout_oe), 32'd0);
      checkOutput("idle_dout", 32'(dout), 32'd0);

      if (did_rst) begin
         exp_last = 0;
         checkOutput("reset_err", 32'(err_count - err_base), 32'd0);
         checkOutput("reset_done", 32'(done_count - done_base), 32'd0);
      end else if (!start) begin
         checkOutput("startbit_dout", 32'(rx), 32'd0);
         checkOutput("startbit_err_early", 32'(err_early), 32'd1);
         checkOutput("startbit_done", 32'(done_count - done_base), 32'd0);
      end else if (n_rises < 18) begin
         if (n_rises > 5) exp_last = addr;
         checkOutput("abort_err", 32'(err_count - err_base), 32'd1);
         checkOutput("abort_done", 32'(done_count - done_base), 32'd0);
      end else begin
         exp_last = addr;
         got_val  = 0;
         for (int r = 6; r < 18; r++) got_val = (got_val << 1) | int'(rx[r]);
         checkOutput("null_bit", 32'(rx[5]), 32'd0);
         checkOutput("sample", 32'(got_val), 32'(exp_val));
         checkOutput("frame_err", 32'(err_count - err_base), (addr >= 4) ? 32'd1 : 32'd0);
         checkOutput("frame_done", 32'(done_count - done_base), (addr >= 4) ? 32'd0 : 32'd1);
      end
      checkOutput("last_addr", 32'(last_addr), 32'(exp_last));
   endtask

   initial begin
      int done_base;
      rst_n = 1'b0;
      sclk  = 1'b0;
      cs_n  = 1'b1;
      din   = 1'b0;
      ch0   = '0;
      ch1   = '0;
      ch2   = '0;
      ch3   = '0;
      repeat (4) @(negedge clk);
      checkOutput("rst_dout", 32'(dout), 32'd0);
      checkOutput("rst_oe", 32'(dout_oe), 32'd0);
      checkOutput("rst_done", 32'(frame_done), 32'd0);
      checkOutput("rst_err", 32'(err), 32'd0);
      checkOutput("rst_last_addr", 32'(last_addr), 32'd0);
      rst_n = 1'b1;
      repeat (2 * PH) @(negedge clk);

      // Basic single-ended read of channel 1
      ch1 = 12'hA5C;
      applyStimulus(1'b1, 1'b1, 1, 18, -1, '0, -1);

      // Back-to-back reads of all four channels
      ch0 = 12'h001; ch1 = 12'h800; ch2 = 12'hFFF; ch3 = 12'h3C3;
      done_base = done_count;
      for (int a = 0; a < 4; a++) applyStimulus(1'b1, 1'b1, a, 18, -1, '0, -1);
      checkOutput("four_done", 32'(done_count - done_base), 32'd4);

      // Pseudo-differential, positive and clamped
      ch2 = 12'h300; ch3 = 12'h100;
      applyStimulus(1'b1, 1'b0, 2, 18, -1, '0, -1);
      applyStimulus(1'b1, 1'b0, 3, 18, -1, '0, -1);

      // Bad start bit, out-of-range address, early abort then recovery
      applyStimulus(1'b0, 1'b1, 1, 18, -1, '0, -1);
      applyStimulus(1'b1, 1'b1, 5, 18, -1, '0, -1);
      applyStimulus(1'b1, 1'b1, 2, 11, -1, '0, -1);
      applyStimulus(1'b1, 1'b1, 2, 18, -1, '0, -1);

      // Channel change mid-frame is not seen until the next frame
      ch1 = 12'h111;
      applyStimulus(1'b1, 1'b1, 1, 18, 8, 12'h222, -1);
      applyStimulus(1'b1, 1'b1, 1, 18, -1, '0, -1);

      // Reset mid-transfer, then a clean frame
      applyStimulus(1'b1, 1'b1, 0, 18, -1, '0, 9);
      applyStimulus(1'b1, 1'b1, 3, 18, -1, '0, -1);

      // Randomized frames
      for (int i = 0; i < 24; i++) begin
         ch0 = 12'($urandom);
         ch1 = 12'($urandom);
         ch2 = 12'($urandom);
         ch3 = 12'($urandom);
         applyStimulus(($urandom_range(0, 7) != 0), 1'($urandom_range(0, 1)),
                       int'($urandom_range(0, 7)), 18, -1, '0, -1);
      end

      checkOutput("done_err_exclusive", 32'(both_count), 32'd0);
      $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
      $finish;
   end

endmodule
